// File: rtl/if_sram_ctrl.sv
// SRAM controller shared by the IF fetch path and the MEM data port; data accesses win arbitration.
// Optional next-line prefetch buffer is enabled by defining IFETCH_PREFETCH_EN.
module if_sram_ctrl #(
    parameter int         WAIT_CYCLES = 2,
    parameter int         ADDR_W      = 20,
    parameter logic [9:0] BASE_HI     = 10'h200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       im_addr,
    output logic [31:0]       im_data,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_dq_o,
    input  logic [31:0]       sram_dq_i,
    output logic              sram_dq_oe,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n
);
    typedef enum logic [2:0] {IDLE, IREAD, DREAD, DWRITE, TURN} state_t;
    localparam logic [2:0] LAST = 3'(WAIT_CYCLES - 1);

    state_t      state;
    logic [2:0]  cnt;
    logic        ivalid;
    logic [31:0] iaddr_q;
    logic [31:0] idata_q;
    logic        main_hit;
    logic        ihit;
    logic        i_in;
    logic        d_in;
    logic        d_start;
    logic        last;
    logic        wr_hit_i;
    logic        unused_bits;

    assign main_hit    = ivalid && (iaddr_q == im_addr);
    assign i_in        = im_addr[31:22] == BASE_HI;
    assign d_in        = mem_addr[31:22] == BASE_HI;
    // mem_req is still high during the ack cycle; it must not launch a second access
    assign d_start     = mem_req && !mem_ack;
    assign last        = cnt == LAST;
    assign wr_hit_i    = mem_addr[ADDR_W+1:2] == iaddr_q[ADDR_W+1:2];
    assign unused_bits = ^{im_addr[1:0], mem_addr[1:0]};

`ifdef IFETCH_PREFETCH_EN
    logic        pvalid;
    logic        pf_q;
    logic        phit;
    logic        promote;
    logic        pf_need;
    logic        wr_hit_p;
    logic [31:0] paddr_q;
    logic [31:0] pdata;
    logic [31:0] pf_addr;

    assign pf_addr  = iaddr_q + 32'd4;
    assign phit     = pvalid && (paddr_q == im_addr);
    assign promote  = phit && !main_hit;
    assign ihit     = main_hit || phit;
    assign im_data  = promote ? pdata : idata_q;
    assign pf_need  = main_hit && (pf_addr[31:22] == BASE_HI) && (!pvalid || paddr_q != pf_addr);
    assign wr_hit_p = mem_addr[ADDR_W+1:2] == paddr_q[ADDR_W+1:2];
`else
    assign ihit    = main_hit;
    assign im_data = idata_q;
`endif

    assign if_stall = ~ihit;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ivalid     <= 1'b0;
            iaddr_q    <= '0;
            idata_q    <= '0;
            mem_rdata  <= '0;
            mem_ack    <= 1'b0;
            sram_addr  <= '0;
            sram_dq_o  <= '0;
            sram_dq_oe <= 1'b0;
            sram_ce_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'hF;
`ifdef IFETCH_PREFETCH_EN
            pvalid     <= 1'b0;
            pf_q       <= 1'b0;
            paddr_q    <= '0;
            pdata      <= '0;
`endif
        end else begin
            mem_ack <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
            if (promote) begin
                idata_q <= pdata;
                iaddr_q <= paddr_q;
                ivalid  <= 1'b1;
            end
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (d_start) begin
                        if (!d_in) begin
                            mem_ack   <= 1'b1;
                            mem_rdata <= '0;
                        end else begin
                            sram_addr <= mem_addr[ADDR_W+1:2];
                            sram_ce_n <= 1'b0;
                            if (mem_we) begin
                                sram_we_n  <= 1'b0;
                                sram_dq_oe <= 1'b1;
                                sram_dq_o  <= mem_wdata;
                                sram_be_n  <= ~mem_be;
                                state      <= DWRITE;
                            end else begin
                                sram_oe_n <= 1'b0;
                                sram_be_n <= 4'h0;
                                state     <= DREAD;
                            end
                        end
                    end else if (!ihit) begin
                        if (!i_in) begin
                            // unmapped fetch returns a NOP without touching the SRAM
                            idata_q <= '0;
                            iaddr_q <= im_addr;
                            ivalid  <= 1'b1;
                        end else begin
                            sram_addr <= im_addr[ADDR_W+1:2];
                            sram_ce_n <= 1'b0;
                            sram_oe_n <= 1'b0;
                            sram_be_n <= 4'h0;
                            state     <= IREAD;
                        end
                    end
`ifdef IFETCH_PREFETCH_EN
                    else if (pf_need) begin
                        sram_addr <= pf_addr[ADDR_W+1:2];
                        sram_ce_n <= 1'b0;
                        sram_oe_n <= 1'b0;
                        sram_be_n <= 4'h0;
                        paddr_q   <= pf_addr;
                        pvalid    <= 1'b0;
                        pf_q      <= 1'b1;
                        state     <= IREAD;
                    end
`endif
                end
                IREAD: begin
                    if (last) begin
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= 4'hF;
                        state     <= IDLE;
`ifdef IFETCH_PREFETCH_EN
                        if (pf_q) begin
                            pdata  <= sram_dq_i;
                            pvalid <= 1'b1;
                            pf_q   <= 1'b0;
                        end else
`endif
                        begin
                            idata_q <= sram_dq_i;
                            iaddr_q <= im_addr;
                            ivalid  <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DREAD: begin
                    if (last) begin
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_be_n <= 4'hF;
                        mem_rdata <= sram_dq_i;
                        mem_ack   <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                DWRITE: begin
                    if (last) begin
                        // strobes rise first; the bus stays driven one more cycle for hold time
                        sram_ce_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        sram_be_n <= 4'hF;
                        cnt       <= '0;
                        state     <= TURN;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                TURN: begin
                    sram_dq_oe <= 1'b0;
                    mem_ack    <= 1'b1;
                    state      <= IDLE;
                    if (wr_hit_i)
                        ivalid <= 1'b0;
`ifdef IFETCH_PREFETCH_EN
                    if (wr_hit_p) begin
                        pvalid <= 1'b0;
                        if (promote)
                            ivalid <= 1'b0;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_if_sram_ctrl.sv
// Directed bench for if_sram_ctrl: fetch/data vector tables plus arbitration, coherence and reset sequences.
module tb_if_sram_ctrl;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] im_addr = 32'hFFFF_FFFF;
    logic [31:0] im_data;
    logic        if_stall;
    logic        mem_req = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_be = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic [19:0] sram_addr;
    logic [31:0] sram_dq_o;
    logic [31:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    always #5 clk = ~clk;

    if_sram_ctrl #(.WAIT_CYCLES(W), .ADDR_W(20), .BASE_HI(10'h200)) dut (
        .clk(clk), .rst(rst),
        .im_addr(im_addr), .im_data(im_data), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
        .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .sram_be_n(sram_be_n)
    );

    // asynchronous SRAM model; the marker value shows up if data is sampled without oe
    logic [31:0] mem [0:63];
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[5:0]] : 32'hBAD0_BAD0;

    int          ce_cyc = 0, oe_cyc = 0, we_cyc = 0, turn_cyc = 0, bad_cnt = 0, log_n = 0;
    logic [19:0] addr_log [0:255];
    logic [3:0]  be_log [0:255];
    logic        prev_ce_n = 1'b1;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 | i;
        mem[0] = 32'h3C01_1234;
        forever begin
            @(posedge clk);
            if (!sram_ce_n && !sram_we_n && sram_dq_oe)
                for (int b = 0; b < 4; b++)
                    if (!sram_be_n[b]) mem[sram_addr[5:0]][8*b +: 8] = sram_dq_o[8*b +: 8];
            @(negedge clk);
            if (!sram_ce_n) ce_cyc++;
            if (!sram_oe_n) oe_cyc++;
            if (!sram_we_n) we_cyc++;
            if (sram_dq_oe && sram_ce_n) turn_cyc++;
            if (!sram_ce_n && prev_ce_n && log_n < 256) begin
                addr_log[log_n] = sram_addr;
                be_log[log_n]   = sram_be_n;
                log_n++;
            end
            prev_ce_n = sram_ce_n;
            if (mem_ack && !mem_req) bad_cnt++;
            if (!sram_oe_n && !sram_we_n) bad_cnt++;
            if (sram_dq_oe && !sram_oe_n) bad_cnt++;
        end
    end

    int errs = 0, checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fetch(input logic [31:0] a, output logic [31:0] d, output int st);
        @(negedge clk);
        im_addr = a;
        #1;
        st = 0;
        while (if_stall && st < 40) begin
            @(negedge clk); #1;
            st++;
        end
        d = im_data;
    endtask

    task automatic dacc(input logic we, input logic [3:0] be, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output int cyc);
        @(negedge clk);
        mem_req = 1'b1; mem_we = we; mem_be = be; mem_addr = a; mem_wdata = wd;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!mem_ack && cyc < 40);
        rd = mem_rdata;
        mem_req = 1'b0; mem_we = 1'b0;
        @(negedge clk); #1;
        chk("ack_single_pulse", mem_ack, 1'b0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          stalls;
        int          ce;
    } fvec_t;

    typedef struct {
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          cyc;
        int          acc;
    } dvec_t;

    fvec_t ft [6];
    dvec_t dt [8];

    initial begin
        logic [31:0] d;
        logic [3:0]  nbe;
        int          st, cyc, n0, c0, o0, w0, t0, acks;

        ft[0] = '{32'h8000_000C, 32'h1000_0003, 3, 2};
        ft[1] = '{32'h8000_000C, 32'h1000_0003, 0, 0};
        ft[2] = '{32'h0000_1000, 32'h0000_0000, 1, 0};
        ft[3] = '{32'h8000_0008, 32'h1000_0002, 3, 2};
        ft[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 1, 0};
        ft[5] = '{32'h8000_0000, 32'h3C01_1234, 3, 2};

        dt[0] = '{1'b0, 4'hF, 32'h8000_0010, 32'h0,         32'h1000_0004, 3, 1};
        dt[1] = '{1'b1, 4'hF, 32'h8000_0014, 32'h1122_3344, 32'h0,         4, 1};
        dt[2] = '{1'b0, 4'hF, 32'h8000_0014, 32'h0,         32'h1122_3344, 3, 1};
        dt[3] = '{1'b1, 4'h8, 32'h8000_0014, 32'hAA00_0000, 32'h0,         4, 1};
        dt[4] = '{1'b0, 4'hF, 32'h8000_0014, 32'h0,         32'hAA22_3344, 3, 1};
        dt[5] = '{1'b0, 4'hF, 32'h4000_0000, 32'h0,         32'h0000_0000, 1, 0};
        dt[6] = '{1'b1, 4'hF, 32'h4000_0014, 32'h5555_5555, 32'h0,         1, 0};
        dt[7] = '{1'b0, 4'hF, 32'h8000_0014, 32'h0,         32'hAA22_3344, 3, 1};

        // reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_if_stall", if_stall, 1'b1);
        chk("rst_im_data", im_data, 32'h0);
        chk("rst_mem_rdata", mem_rdata, 32'h0);
        chk("rst_mem_ack", mem_ack, 1'b0);
        chk("rst_ce_n", sram_ce_n, 1'b1);
        chk("rst_oe_n", sram_oe_n, 1'b1);
        chk("rst_we_n", sram_we_n, 1'b1);
        chk("rst_be_n", sram_be_n, 4'hF);
        chk("rst_dq_oe", sram_dq_oe, 1'b0);
        chk("rst_sram_addr", sram_addr, 20'h0);
        rst = 1'b1;
        chk("boot_stall_first", if_stall, 1'b1);
        @(negedge clk); #1;
        chk("boot_stall_released", if_stall, 1'b0);
        chk("boot_nop", im_data, 32'h0);
        chk("boot_no_ce", ce_cyc, 0);

        // first in-range fetch
        n0 = log_n; c0 = ce_cyc; o0 = oe_cyc;
        fetch(32'h8000_0000, d, st);
        chk("fetch0_stalls", st, W + 1);
        chk("fetch0_data", d, 32'h3C01_1234);
        chk("fetch0_ce_cycles", ce_cyc - c0, W);
        chk("fetch0_oe_cycles", oe_cyc - o0, W);
        chk("fetch0_addr", addr_log[n0], 20'h0);

        for (int i = 0; i < 6; i++) begin
            n0 = log_n; c0 = ce_cyc;
            fetch(ft[i].addr, d, st);
            chk($sformatf("ftab%0d_stalls", i), st, ft[i].stalls);
            chk($sformatf("ftab%0d_data", i), d, ft[i].data);
            chk($sformatf("ftab%0d_ce", i), ce_cyc - c0, ft[i].ce);
            if (ft[i].ce != 0)
                chk($sformatf("ftab%0d_addr", i), addr_log[n0], {12'h0, ft[i].addr[21:2]} & 32'hF_FFFF);
        end

        for (int i = 0; i < 8; i++) begin
            n0 = log_n; w0 = we_cyc;
            dacc(dt[i].we, dt[i].be, dt[i].addr, dt[i].wdata, d, cyc);
            chk($sformatf("dtab%0d_cycles", i), cyc, dt[i].cyc);
            chk($sformatf("dtab%0d_accesses", i), log_n - n0, dt[i].acc);
            if (!dt[i].we)
                chk($sformatf("dtab%0d_rdata", i), d, dt[i].rdata);
            if (dt[i].we && dt[i].acc != 0) begin
                nbe = ~dt[i].be;
                chk($sformatf("dtab%0d_we_cycles", i), we_cyc - w0, W);
                chk($sformatf("dtab%0d_be_n", i), be_log[n0], nbe);
            end
        end
        chk("dtab_fetch_still_hit", if_stall, 1'b0);

        // simultaneous instruction miss and data read: data goes first
        @(negedge clk);
        n0 = log_n;
        im_addr = 32'h8000_0008;
        mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h8000_0010;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!mem_ack && cyc < 40);
        chk("arb_ack_cycles", cyc, W + 1);
        chk("arb_rdata", mem_rdata, 32'h1000_0004);
        chk("arb_stall_at_ack", if_stall, 1'b1);
        mem_req = 1'b0;
        st = 0;
        while (if_stall && st < 40) begin
            @(negedge clk); #1;
            if (st == 0) chk("arb_ack_single", mem_ack, 1'b0);
            st++;
        end
        chk("arb_refill_cycles", st, W + 1);
        chk("arb_idata", im_data, 32'h1000_0002);
        chk("arb_first_addr", addr_log[n0], 20'h4);
        chk("arb_second_addr", addr_log[n0+1], 20'h2);

        // partial write to the word currently held in the fetch buffer
        fetch(32'h8000_0000, d, st);
        chk("coh_prefetch_data", d, 32'h3C01_1234);
        n0 = log_n; w0 = we_cyc; t0 = turn_cyc;
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011;
        mem_addr = 32'h8000_0000; mem_wdata = 32'hDEAD_BEEF;
        cyc = 0;
        do begin
            @(negedge clk); #1;
            cyc++;
        end while (!mem_ack && cyc < 40);
        mem_req = 1'b0; mem_we = 1'b0;
        chk("coh_ack_cycles", cyc, W + 2);
        chk("coh_we_cycles", we_cyc - w0, W);
        chk("coh_turn_cycles", turn_cyc - t0, 1);
        chk("coh_be_n", be_log[n0], 4'b1100);
        chk("coh_stall_at_ack", if_stall, 1'b1);
        st = 0;
        while (if_stall && st < 40) begin
            @(negedge clk); #1;
            st++;
        end
        chk("coh_refetch_cycles", st, W + 1);
        chk("coh_refetch_data", im_data, 32'h3C01_BEEF);

        // reset in the second DWRITE cycle aborts the access
        @(negedge clk);
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'hF;
        mem_addr = 32'h8000_0020; mem_wdata = 32'h7777_7777;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk); #1;
        chk("abort_ce_n", sram_ce_n, 1'b1);
        chk("abort_we_n", sram_we_n, 1'b1);
        chk("abort_oe_n", sram_oe_n, 1'b1);
        chk("abort_be_n", sram_be_n, 4'hF);
        chk("abort_dq_oe", sram_dq_oe, 1'b0);
        chk("abort_no_ack", mem_ack, 1'b0);
        chk("abort_ivalid_cleared", if_stall, 1'b1);
        mem_req = 1'b0; mem_we = 1'b0;
        rst = 1'b1;
        acks = 0; st = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            if (mem_ack) acks++;
            if (if_stall) st++;
        end
        chk("abort_no_late_ack", acks, 0);
        chk("abort_refetch_stalls", st, W);
        chk("abort_refetch_data", im_data, 32'h3C01_BEEF);

`ifdef IFETCH_PREFETCH_EN
        fetch(32'h8000_0030, d, st);
        chk("pf_first_data", d, 32'h1000_000C);
        repeat (8) @(negedge clk);
        fetch(32'h8000_0034, d, st);
        chk("pf_seq_stalls", st, 0);
        chk("pf_seq_data", d, 32'h1000_000D);
`endif

        chk("protocol_violations", bad_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end
endmodule
